// File: rtl/fft_control_fsm_if.sv
// Control bundle between the FFT sequencer and its surroundings: the host
// byte handshakes, the timer enables/done-flags, the sample-memory strobes
// and the status/debug outputs.
interface fft_control_fsm_if;
    // host side
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;

    // timer done-flags
    logic       samples_loaded_done;
    logic       samples_in_done;
    logic       iteration_done;
    logic       fft_done;
    logic       samples_written_done;
    logic       samples_out_done;

    // timer enables
    logic       shift_in_ena;
    logic       iteration_ena;
    logic       shift_out_ena;

    // sample-memory strobes
    logic       sample_wr;
    logic       stage_adv;
    logic       sample_rd;

    // status
    logic       busy;
    logic       fft_complete;
    logic [2:0] state_out;

    // sequencer side
    modport master (
        input  start, in_valid, out_ready,
        input  samples_loaded_done, samples_in_done, iteration_done,
        input  fft_done, samples_written_done, samples_out_done,
        output in_ready, out_valid,
        output shift_in_ena, iteration_ena, shift_out_ena,
        output sample_wr, stage_adv, sample_rd,
        output busy, fft_complete, state_out
    );

    // host / timer / memory side
    modport slave (
        output start, in_valid, out_ready,
        output samples_loaded_done, samples_in_done, iteration_done,
        output fft_done, samples_written_done, samples_out_done,
        input  in_ready, out_valid,
        input  shift_in_ena, iteration_ena, shift_out_ena,
        input  sample_wr, stage_adv, sample_rd,
        input  busy, fft_complete, state_out
    );
endinterface

// File: rtl/fft_control_fsm.sv
// Top-level sequencer of the 8-point FFT core. Walks a frame through
// load (6 bytes x 8 samples), compute (16 iterations x 8 stages) and
// unload (4 bytes x 8 samples), steering the timer enables from the
// timer's done-flags. Outputs are decoded combinationally from state.
module fft_control_fsm #(
    parameter int OUT_FETCH_LAT = 1     // sample-memory read latency, 1..7
) (
    input  logic              clk,
    input  logic              n_rst,
    fft_control_fsm_if.master bus
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
        STORE      = 3'd2,
        COMPUTE    = 3'd3,
        STAGE_SYNC = 3'd4,
        FETCH      = 3'd5,
        SHIFT_OUT  = 3'd6,
        DONE       = 3'd7
    } state_t;

    localparam logic [2:0] FETCH_LAST = 3'(OUT_FETCH_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] fetch_cnt;      // cycles spent in the current FETCH visit
    logic [2:0] smp_cnt;        // output samples already unloaded this frame
    logic       last_smp;

    // samples_out_done arrives one cycle too late for the FETCH/DONE
    // decision; the local sample counter is used instead.
    logic       unused_flags;
    assign unused_flags = bus.samples_out_done;

    assign last_smp = (smp_cnt == 3'd7);

    // State register.
    always_ff @(posedge clk) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // FETCH latency counter: zero outside FETCH, so every entry starts clean.
    always_ff @(posedge clk) begin
        if (!n_rst || state != FETCH) fetch_cnt <= 3'd0;
        else                          fetch_cnt <= fetch_cnt + 3'd1;
    end

    // Output sample counter: one step per completed output sample.
    always_ff @(posedge clk) begin
        if (!n_rst || state == IDLE)
            smp_cnt <= 3'd0;
        else if (state == SHIFT_OUT && bus.samples_written_done)
            smp_cnt <= smp_cnt + 3'd1;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (bus.start) state_nxt = LOAD;
            LOAD:       if (bus.samples_loaded_done) state_nxt = STORE;
            STORE:      state_nxt = bus.samples_in_done ? COMPUTE : LOAD;
            COMPUTE:    if (bus.iteration_done) state_nxt = STAGE_SYNC;
            STAGE_SYNC: state_nxt = bus.fft_done ? FETCH : COMPUTE;
            FETCH:      if (fetch_cnt == FETCH_LAST) state_nxt = SHIFT_OUT;
            SHIFT_OUT:  if (bus.samples_written_done)
                            state_nxt = last_smp ? DONE : FETCH;
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Output decode. Everything defaults low, which keeps IDLE silent and
    // guarantees at most one timer enable per cycle (one per state).
    always_comb begin
        bus.in_ready      = 1'b0;
        bus.out_valid     = 1'b0;
        bus.shift_in_ena  = 1'b0;
        bus.iteration_ena = 1'b0;
        bus.shift_out_ena = 1'b0;
        bus.sample_wr     = 1'b0;
        bus.stage_adv     = 1'b0;
        bus.sample_rd     = 1'b0;
        bus.fft_complete  = 1'b0;
        bus.busy          = (state != IDLE);
        bus.state_out     = state;
        case (state)
            LOAD: begin
                // drop ready in the flag cycle so a 7th byte is never taken
                bus.in_ready     = ~bus.samples_loaded_done;
                bus.shift_in_ena = bus.in_valid & ~bus.samples_loaded_done;
            end
            STORE:      bus.sample_wr     = 1'b1;
            COMPUTE:    bus.iteration_ena = ~bus.iteration_done;
            STAGE_SYNC: bus.stage_adv     = 1'b1;
            FETCH:      bus.sample_rd     = (fetch_cnt == 3'd0);
            SHIFT_OUT: begin
                bus.out_valid     = ~bus.samples_written_done;
                bus.shift_out_ena = bus.out_ready & ~bus.samples_written_done;
            end
            DONE:       bus.fft_complete  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fft_control_fsm.sv
// Bench for fft_control_fsm: a behavioural timer drives the flags of the
// main instance, a second instance with OUT_FETCH_LAT=3 is stepped by hand.
module tb_fft_control_fsm;

    localparam int N_SMP   = 8;
    localparam int B_IN    = 6;
    localparam int N_IT    = 16;
    localparam int N_STG   = 8;
    localparam int B_OUT   = 4;
    localparam int CYC_MAX = 4000;

    logic clk;
    logic n_rst;

    fft_control_fsm_if b1();
    fft_control_fsm_if b2();

    fft_control_fsm #(.OUT_FETCH_LAT(1)) dut1 (.clk(clk), .n_rst(n_rst), .bus(b1));
    fft_control_fsm #(.OUT_FETCH_LAT(3)) dut2 (.clk(clk), .n_rst(n_rst), .bus(b2));

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cnt[7];         // shift_in, sample_wr, iteration, stage_adv, sample_rd, shift_out, complete
    int exp_cnt[7];
    int bytes_in, bytes_out;
    bit seen_cmp;
    bit mon_en = 0;

    // timer model state
    int ld_cnt, in_cnt, it_cnt, stg_cnt, wr_cnt, out_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame totals from the frame structure alone.
    initial exp_cnt = '{N_SMP*B_IN, N_SMP, N_IT*N_STG, N_STG, N_SMP, N_SMP*B_OUT, 1};

    // Behavioural six-counter timer for the main instance.
    always @(posedge clk) begin
        if (!n_rst || !b1.busy) begin
            ld_cnt <= 0; in_cnt <= 0; it_cnt <= 0; stg_cnt <= 0; wr_cnt <= 0; out_cnt <= 0;
            b1.samples_loaded_done  <= 1'b0;
            b1.iteration_done       <= 1'b0;
            b1.samples_written_done <= 1'b0;
        end else begin
            b1.samples_loaded_done  <= 1'b0;
            b1.iteration_done       <= 1'b0;
            b1.samples_written_done <= 1'b0;
            if (b1.shift_in_ena) begin
                if (ld_cnt == B_IN-1) begin
                    ld_cnt <= 0; in_cnt <= in_cnt + 1; b1.samples_loaded_done <= 1'b1;
                end else ld_cnt <= ld_cnt + 1;
            end
            if (b1.iteration_ena) begin
                if (it_cnt == N_IT-1) begin
                    it_cnt <= 0; stg_cnt <= stg_cnt + 1; b1.iteration_done <= 1'b1;
                end else it_cnt <= it_cnt + 1;
            end
            if (b1.shift_out_ena) begin
                if (wr_cnt == B_OUT-1) begin
                    wr_cnt <= 0; out_cnt <= out_cnt + 1; b1.samples_written_done <= 1'b1;
                end else wr_cnt <= wr_cnt + 1;
            end
        end
    end
    assign b1.samples_in_done  = (in_cnt  == N_SMP);
    assign b1.fft_done         = (stg_cnt == N_STG);
    assign b1.samples_out_done = (out_cnt == N_SMP);

    function automatic logic [9:0] outs1();
        return {b1.in_ready, b1.out_valid, b1.shift_in_ena, b1.iteration_ena, b1.shift_out_ena,
                b1.sample_wr, b1.stage_adv, b1.sample_rd, b1.busy, b1.fft_complete};
    endfunction

    function automatic logic [9:0] outs2();
        return {b2.in_ready, b2.out_valid, b2.shift_in_ena, b2.iteration_ena, b2.shift_out_ena,
                b2.sample_wr, b2.stage_adv, b2.sample_rd, b2.busy, b2.fft_complete};
    endfunction

    // Event counting and per-cycle rules on the main instance.
    always @(negedge clk) begin
        if (mon_en) begin
            if (b1.shift_in_ena)  begin cnt[0]++; bytes_in++;  end
            if (b1.iteration_ena) cnt[2]++;
            if (b1.stage_adv)     cnt[3]++;
            if (b1.sample_rd)     cnt[4]++;
            if (b1.shift_out_ena) begin cnt[5]++; bytes_out++; end
            if (b1.fft_complete)  begin cnt[6]++; seen_cmp = 1'b1; end
            if (b1.sample_wr) begin
                cnt[1]++;
                chk_cnt++;
                if (bytes_in !== B_IN) $display("FAIL bytes_per_sample_in: got %0d want %0d", bytes_in, B_IN);
                else pass_cnt++;
                bytes_in = 0;
            end
            if (b1.state_out == 3'd6 && b1.samples_written_done) begin
                chk_cnt++;
                if (bytes_out !== B_OUT) $display("FAIL bytes_per_sample_out: got %0d want %0d", bytes_out, B_OUT);
                else pass_cnt++;
                bytes_out = 0;
            end
            chk_cnt++;
            if (int'(b1.shift_in_ena) + int'(b1.iteration_ena) + int'(b1.shift_out_ena) > 1)
                $display("FAIL enable_exclusive: got %b%b%b want at most one",
                         b1.shift_in_ena, b1.iteration_ena, b1.shift_out_ena);
            else pass_cnt++;
            chk_cnt++;
            if (b1.busy !== (b1.state_out != 3'd0))
                $display("FAIL busy_vs_state: got busy=%b state=%0d", b1.busy, b1.state_out);
            else pass_cnt++;
            if (b1.state_out == 3'd0) begin
                chk_cnt++;
                if (outs1() !== 10'd0) $display("FAIL idle_outputs: got %b want 0", outs1());
                else pass_cnt++;
            end
            if (b1.samples_loaded_done || b1.state_out == 3'd2) begin
                chk_cnt++;
                if (b1.in_ready !== 1'b0) $display("FAIL in_ready_blocked: got %b want 0", b1.in_ready);
                else pass_cnt++;
            end
            if (b1.state_out == 3'd7) begin
                chk_cnt++;
                if (b1.samples_out_done !== 1'b1)
                    $display("FAIL done_vs_samples_out_done: got %b want 1", b1.samples_out_done);
                else pass_cnt++;
            end
        end
    end

    task automatic clear_counts();
        for (int k = 0; k < 7; k++) cnt[k] = 0;
        bytes_in  = 0;
        bytes_out = 0;
        seen_cmp  = 1'b0;
    endtask

    task automatic test_reset();
        b1.start = 1'b1; b1.in_valid = 1'b1; b1.out_ready = 1'b1;
        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++;
        if (b1.state_out !== 3'd0 || outs1() !== 10'd0)
            $display("FAIL reset_dut1: got state=%0d outs=%b want 0/0", b1.state_out, outs1());
        else pass_cnt++;
        chk_cnt++;
        if (b2.state_out !== 3'd0 || outs2() !== 10'd0)
            $display("FAIL reset_dut2: got state=%0d outs=%b want 0/0", b2.state_out, outs2());
        else pass_cnt++;
        b1.start = 1'b0; b1.in_valid = 1'b0; b1.out_ready = 1'b0;
        // flags into an idle sequencer must be ignored
        b2.samples_loaded_done = 1'b1; b2.samples_in_done = 1'b1; b2.iteration_done = 1'b1;
        b2.fft_done = 1'b1; b2.samples_written_done = 1'b1; b2.in_valid = 1'b1; b2.out_ready = 1'b1;
        n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++;
        if (b2.state_out !== 3'd0 || outs2() !== 10'd0)
            $display("FAIL idle_ignores_flags: got state=%0d outs=%b want 0/0", b2.state_out, outs2());
        else pass_cnt++;
        b2.samples_loaded_done = 1'b0; b2.samples_in_done = 1'b0; b2.iteration_done = 1'b0;
        b2.fft_done = 1'b0; b2.samples_written_done = 1'b0; b2.in_valid = 1'b0; b2.out_ready = 1'b0;
    endtask

    task automatic test_full_frame();
        clear_counts();
        b1.in_valid = 1'b1; b1.out_ready = 1'b1; b1.start = 1'b1;
        @(posedge clk); #1;
        b1.start = 1'b0;
        for (int c = 0; c < CYC_MAX && !(seen_cmp && b1.state_out == 3'd0); c++) begin
            @(posedge clk); #1;
        end
        chk_cnt++;
        if (!seen_cmp) $display("FAIL full_frame_timeout: got no fft_complete in %0d cycles", CYC_MAX);
        else pass_cnt++;
        for (int k = 0; k < 7; k++) begin
            chk_cnt++;
            if (cnt[k] !== exp_cnt[k]) $display("FAIL full_frame_count%0d: got %0d want %0d", k, cnt[k], exp_cnt[k]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (b1.state_out !== 3'd0) $display("FAIL full_frame_end_state: got %0d want 0", b1.state_out);
        else pass_cnt++;
    endtask

    task automatic test_input_gaps();
        clear_counts();
        b1.start = 1'b1; b1.in_valid = 1'b0; b1.out_ready = 1'b1;
        @(posedge clk); #1;
        b1.start = 1'b0;
        for (int c = 0; c < CYC_MAX && !(seen_cmp && b1.state_out == 3'd0); c++) begin
            b1.in_valid  = (c % 3 == 0);
            b1.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        chk_cnt++;
        if (!seen_cmp) $display("FAIL gaps_timeout: got no fft_complete in %0d cycles", CYC_MAX);
        else pass_cnt++;
        for (int k = 0; k < 7; k++) begin
            chk_cnt++;
            if (cnt[k] !== exp_cnt[k]) $display("FAIL gaps_count%0d: got %0d want %0d", k, cnt[k], exp_cnt[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        bit bp_done = 1'b0;
        clear_counts();
        b1.start = 1'b1; b1.in_valid = 1'b1; b1.out_ready = 1'b1;
        @(posedge clk); #1;
        b1.start = 1'b0;
        for (int c = 0; c < CYC_MAX && !(seen_cmp && b1.state_out == 3'd0); c++) begin
            b1.in_valid  = 1'($urandom_range(0, 1));
            b1.out_ready = 1'b1;
            if (!bp_done && cnt[5] == 2*B_OUT + 2) begin
                bp_done = 1'b1;
                b1.out_ready = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    chk_cnt++;
                    if (b1.out_valid !== 1'b1 || b1.shift_out_ena !== 1'b0 || b1.state_out !== 3'd6)
                        $display("FAIL backpressure_hold%0d: got valid=%b ena=%b state=%0d want 1/0/6",
                                 j, b1.out_valid, b1.shift_out_ena, b1.state_out);
                    else pass_cnt++;
                    @(posedge clk); #1;
                end
                b1.out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        chk_cnt++;
        if (!bp_done || !seen_cmp) $display("FAIL backpressure_progress: got bp=%b done=%b want 1/1", bp_done, seen_cmp);
        else pass_cnt++;
        for (int k = 0; k < 7; k++) begin
            chk_cnt++;
            if (cnt[k] !== exp_cnt[k]) $display("FAIL backpressure_count%0d: got %0d want %0d", k, cnt[k], exp_cnt[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_compute();
        int c;
        clear_counts();
        b1.start = 1'b1; b1.in_valid = 1'b1; b1.out_ready = 1'b1;
        @(posedge clk); #1;
        b1.start = 1'b0;
        for (c = 0; c < CYC_MAX && cnt[2] < 40; c++) begin
            @(posedge clk); #1;
        end
        chk_cnt++;
        if (cnt[2] < 40 || b1.state_out !== 3'd3)
            $display("FAIL mid_compute_reach: got iter=%0d state=%0d want >=40/3", cnt[2], b1.state_out);
        else pass_cnt++;
        n_rst = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1;
        chk_cnt++;
        if (b1.state_out !== 3'd0 || outs1() !== 10'd0)
            $display("FAIL mid_compute_reset: got state=%0d outs=%b want 0/0", b1.state_out, outs1());
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_busy_start();
        bit p_load = 1'b0, p_comp = 1'b0, p_done = 1'b0;
        int pend = 0;
        clear_counts();
        b1.start = 1'b1; b1.in_valid = 1'b1; b1.out_ready = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < CYC_MAX && !(seen_cmp && b1.state_out == 3'd0 && pend == 0); c++) begin
            b1.start = 1'b0; b1.in_valid = 1'b1;
            if (pend != 0) begin
                chk_cnt++;
                if (b1.state_out !== 3'((pend == 7) ? 0 : pend))
                    $display("FAIL busy_start_s%0d: got state=%0d", pend, b1.state_out);
                else pass_cnt++;
                pend = 0;
            end
            if (!p_load && b1.state_out == 3'd1 && !b1.samples_loaded_done) begin
                b1.start = 1'b1; b1.in_valid = 1'b0; p_load = 1'b1; pend = 1;
            end else if (!p_comp && b1.state_out == 3'd3 && !b1.iteration_done) begin
                b1.start = 1'b1; p_comp = 1'b1; pend = 3;
            end else if (!p_done && b1.state_out == 3'd7) begin
                b1.start = 1'b1; p_done = 1'b1; pend = 7;
            end
            @(posedge clk); #1;
        end
        b1.start = 1'b0;
        @(posedge clk); #1;
        chk_cnt++;
        if (!(p_load && p_comp && p_done) || b1.state_out !== 3'd0)
            $display("FAIL busy_start_end: got pulses=%b%b%b state=%0d want 111/0", p_load, p_comp, p_done, b1.state_out);
        else pass_cnt++;
        for (int k = 0; k < 7; k++) begin
            chk_cnt++;
            if (cnt[k] !== exp_cnt[k]) $display("FAIL busy_start_count%0d: got %0d want %0d", k, cnt[k], exp_cnt[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_fetch_latency();
        logic [2:0] exp_s[8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd5, 3'd6};
        logic       exp_rd[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        b2.out_ready = 1'b0;
        @(posedge clk); #1;
        b2.start = 1'b1;
        for (int s = 0; s < 8; s++) begin
            @(posedge clk); #1;
            b2.start               = 1'b0;
            b2.samples_loaded_done = (s == 0);
            b2.samples_in_done     = (s == 1);
            b2.iteration_done      = (s == 2);
            b2.fft_done            = (s == 3);
            chk_cnt++;
            if (b2.state_out !== exp_s[s] || b2.sample_rd !== exp_rd[s])
                $display("FAIL fetch_lat_step%0d: got state=%0d rd=%b want %0d/%b",
                         s, b2.state_out, b2.sample_rd, exp_s[s], exp_rd[s]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (b2.out_valid !== 1'b1) $display("FAIL fetch_lat_out_valid: got %b want 1", b2.out_valid);
        else pass_cnt++;
    endtask

    initial begin
        b1.start = 1'b0; b1.in_valid = 1'b0; b1.out_ready = 1'b0;
        b2.start = 1'b0; b2.in_valid = 1'b0; b2.out_ready = 1'b0;
        b2.samples_loaded_done = 1'b0; b2.samples_in_done = 1'b0; b2.iteration_done = 1'b0;
        b2.fft_done = 1'b0; b2.samples_written_done = 1'b0; b2.samples_out_done = 1'b0;
        clear_counts();
        test_reset();
        mon_en = 1'b1;
        test_full_frame();
        test_input_gaps();
        test_backpressure();
        test_reset_mid_compute();
        test_full_frame();
        test_busy_start();
        test_fetch_latency();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
